// File: rtl/dram_cpu_arb_pkg.sv
// Shared types and constants for the DRAM CPU/video slot arbiter.
// Optional refresh support is enabled with the DRAM_REFRESH_EN macro.
package dram_cpu_arb_pkg;

   localparam int ADDR_W = 21;

   // All-ones word address marks a refresh command to the controller.
   localparam logic [ADDR_W-1:0] REF_ADDR = {ADDR_W{1'b1}};

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      CPU_RD = 3'd1,
      CPU_WR = 3'd2,
      VID    = 3'd3,
      REF    = 3'd4
   } owner_t;

   // Byte enables for a CPU byte write: high byte lives in bits 15:8.
   function automatic logic [1:0] wr_bsel(input logic hi_byte);
      return hi_byte ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/dram_slot_ctr.sv
// Refresh slot counter: counts slot boundaries (c3) and flags refresh_due
// once REF_PERIOD-1 slots have passed since reset or the last refresh.
// Only instantiated when DRAM_REFRESH_EN is defined.
module dram_slot_ctr #(
   parameter int REF_PERIOD = 96
) (
   input  logic clk,
   input  logic rst,
   input  logic c3,
   input  logic ref_grant,
   output logic refresh_due
);

   localparam int CNT_W = $clog2(REF_PERIOD);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REF_PERIOD - 1);

   logic [CNT_W-1:0] slot_cnt;

   // Count slots, restart on refresh grant, hold at the due point.
   always_ff @(posedge clk) begin
      if (rst) begin
         slot_cnt <= '0;
      end else if (c3) begin
         if (ref_grant) begin
            slot_cnt <= '0;
         end else if (slot_cnt != CNT_LAST) begin
            slot_cnt <= slot_cnt + 1'b1;
         end
      end
   end

   assign refresh_due = (slot_cnt == CNT_LAST);

endmodule

// File: rtl/dram_cpu_arb.sv
// DRAM slot arbiter between the Z80 memory port and the video fetcher.
// One controller command per 4-clk slot (c0..c3); ownership is decided at
// c3 and applies from the next c0. Read data is returned to the CPU side
// with a strobe/latch handshake.
// Optional refresh slots: define DRAM_REFRESH_EN.
//
// owner  | meaning
// -------+----------------------------------------------
// IDLE   | no command this slot
// CPU_RD | CPU word read, data captured at mem_rdvalid
// CPU_WR | CPU byte write, no data return
// VID    | video fetch, data passed through on vid_strobe
// REF    | refresh command (only with refresh enabled)
module dram_cpu_arb
   import dram_cpu_arb_pkg::*;
#(
   parameter int VID_RUN_MAX = 4,
   parameter int REF_PERIOD  = 96
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              c0,
   input  logic              c1,
   input  logic              c2,
   input  logic              c3,
   input  logic              cpu_req,
   input  logic              cpu_rnw,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic              cpu_wrbsel,
   input  logic [7:0]        cpu_wrdata,
   output logic              cpu_next,
   output logic              cpu_strobe,
   output logic              cpu_latch,
   output logic [15:0]       cpu_rddata,
   input  logic              vid_req,
   input  logic [ADDR_W-1:0] vid_addr,
   output logic              vid_strobe,
   output logic              mem_req,
   output logic              mem_rnw,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [1:0]        mem_bsel,
   output logic [15:0]       mem_wrdata,
   input  logic [15:0]       mem_rddata,
   input  logic              mem_rdvalid
);

   localparam int RUN_W = $clog2(VID_RUN_MAX + 1);
   localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(VID_RUN_MAX);

   owner_t           owner;
   owner_t           owner_nxt;
   logic [RUN_W-1:0] vid_run;
   logic             refresh_due;
   logic             starve;
   logic             cpu_grant;
   logic             vid_grant;
   logic             ref_grant;
   logic             rd_capture;
   logic [2:0]       latch_cnt;

`ifdef DRAM_REFRESH_EN
   dram_slot_ctr #(
      .REF_PERIOD (REF_PERIOD)
   ) u_slot_ctr (
      .clk         (clk),
      .rst         (rst),
      .c3          (c3),
      .ref_grant   (ref_grant),
      .refresh_due (refresh_due)
   );

   // Only c0 and c3 carry decisions; c1/c2 are part of the phase bundle.
   logic unused_phase;
   assign unused_phase = &{1'b0, c1, c2};
`else
   assign refresh_due = 1'b0;

   logic unused_phase;
   assign unused_phase = &{1'b0, c1, c2, ref_grant, REF_PERIOD[0]};
`endif

   assign starve   = (vid_run == RUN_MAX);
   assign cpu_next = !refresh_due && (!vid_req || starve);

   // Owner register: changes only at the slot boundary.
   always_ff @(posedge clk) begin
      if (rst) begin
         owner <= IDLE;
      end else begin
         owner <= owner_nxt;
      end
   end

   // Grant decision at c3 plus per-slot command/strobe outputs.
   always_comb begin
      owner_nxt  = owner;
      cpu_grant  = 1'b0;
      vid_grant  = 1'b0;
      ref_grant  = 1'b0;
      if (c3) begin
         if (refresh_due) begin
            owner_nxt = REF;
            ref_grant = 1'b1;
         end else if (cpu_req && cpu_next) begin
            owner_nxt = cpu_rnw ? CPU_RD : CPU_WR;
            cpu_grant = 1'b1;
         end else if (vid_req) begin
            owner_nxt = VID;
            vid_grant = 1'b1;
         end else begin
            owner_nxt = IDLE;
         end
      end

      mem_req = 1'b0;
      case (owner)
         CPU_RD, CPU_WR, VID: mem_req = c0;
`ifdef DRAM_REFRESH_EN
         REF:                 mem_req = c0;
`endif
         default:             mem_req = 1'b0;
      endcase

      vid_strobe = mem_rdvalid && (owner == VID);
      rd_capture = mem_rdvalid && (owner == CPU_RD);
   end

   // Consecutive video grants while the CPU waits; saturates at the cap.
   always_ff @(posedge clk) begin
      if (rst) begin
         vid_run <= '0;
      end else if (c3) begin
         if (cpu_grant || !cpu_req) begin
            vid_run <= '0;
         end else if (vid_grant && !starve) begin
            vid_run <= vid_run + 1'b1;
         end
      end
   end

   // Command fields captured at grant and held for the whole slot.
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_addr   <= '0;
         mem_rnw    <= 1'b0;
         mem_bsel   <= 2'b00;
         mem_wrdata <= '0;
      end else if (cpu_grant) begin
         mem_addr   <= cpu_addr;
         mem_rnw    <= cpu_rnw;
         mem_bsel   <= cpu_rnw ? 2'b11 : wr_bsel(cpu_wrbsel);
         mem_wrdata <= {cpu_wrdata, cpu_wrdata};
      end else if (vid_grant) begin
         mem_addr   <= vid_addr;
         mem_rnw    <= 1'b1;
         mem_bsel   <= 2'b11;
      end else if (ref_grant) begin
         mem_addr   <= REF_ADDR;
         mem_rnw    <= 1'b1;
         mem_bsel   <= 2'b11;
      end
   end

   // CPU read return: capture data, strobe next clk, hold latch for 4 clks.
   always_ff @(posedge clk) begin
      if (rst) begin
         cpu_rddata <= '0;
         cpu_strobe <= 1'b0;
         latch_cnt  <= 3'd0;
      end else begin
         cpu_strobe <= rd_capture;
         if (rd_capture) begin
            cpu_rddata <= mem_rddata;
            latch_cnt  <= 3'd4;
         end else if (latch_cnt != 3'd0) begin
            latch_cnt  <= latch_cnt - 3'd1;
         end
      end
   end

   assign cpu_latch = (latch_cnt != 3'd0);

endmodule

// File: doc/dram_cpu_arb.md
Name: dram_cpu_arb

Overview:
- DRAM-side responder for the Z80 CPU memory port: arbitrates DRAM slots between the CPU and the video fetcher, drives one memory controller command per 4-clock slot, and returns read data to the CPU side.
- Produces the cpu_next / cpu_strobe / cpu_latch handshake consumed by the Z80 memory manager and its line cache.
- Sits between that manager, the video fetcher and the DRAM controller, on the main clk with the c0..c3 phase strobes.

Parameters:
- VID_RUN_MAX, 4: maximum consecutive video slots granted while cpu_req is pending; after that the CPU is guaranteed one slot.
- REF_PERIOD, 96: slots between refresh cycles (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- c0, c1, c2, c3  in  1 each  one-hot slot phase strobes, one clk each, repeating c0..c3.
- cpu_req  in  1  CPU requests the next slot; sampled at c3.
- cpu_rnw  in  1  1 = read, 0 = byte write.
- cpu_addr  in  21  word address.
- cpu_wrbsel  in  1  byte select: 0 = low byte, 1 = high byte.
- cpu_wrdata  in  8  write byte.
- cpu_next  out  1  the next slot is available to the CPU.
- cpu_strobe  out  1  one-clk pulse when cpu_rddata is newly valid.
- cpu_latch  out  1  cpu_rddata is current (selects it over cached data).
- cpu_rddata  out  16  read word.
- vid_req  in  1  video fetch request; sampled at c3.
- vid_addr  in  21  video word address.
- vid_strobe  out  1  one-clk pulse when video data is valid on mem_rddata.
- mem_req  out  1  command valid, c0 clk of the slot.
- mem_rnw  out  1  command direction.
- mem_addr  out  21  command address.
- mem_bsel  out  2  byte enables for writes.
- mem_wrdata  out  16  write word.
- mem_rddata  in  16  read data from the controller.
- mem_rdvalid  in  1  read data valid; expected at c2 of the owning slot.

Behaviour:
- Slot owner register, states IDLE, CPU_RD, CPU_WR, VID, REF. It is updated only on the clk where c3 is high, and the new owner applies from the following c0.
- Grant priority at c3:
  - REF if refresh_due.
  - Else CPU if cpu_req && cpu_next.
  - Else VID if vid_req.
  - Else IDLE.
- cpu_next is combinational: cpu_next = !refresh_due && (!vid_req || starve).
- starve = (vid_run == VID_RUN_MAX).
- vid_run counter, 0..VID_RUN_MAX, updated at c3:
  - Cleared when the CPU is granted, or when cpu_req is low.
  - Incremented (saturating) when VID is granted while cpu_req is high.
- Command outputs:
  - mem_req = 1 on the c0 clk of CPU_RD, CPU_WR and VID slots; 0 otherwise, including REF with the feature off.
  - mem_addr, mem_rnw, mem_bsel and mem_wrdata are registered at the grant and held for the whole slot.
  - CPU write: mem_bsel = cpu_wrbsel ? 2'b10 : 2'b01; mem_wrdata = {cpu_wrdata, cpu_wrdata}.
  - Reads: mem_bsel = 2'b11.
- CPU read return:
  - When mem_rdvalid is high in a CPU_RD slot, mem_rddata is registered into cpu_rddata.
  - cpu_strobe pulses on the next clk (c3 of the slot, nominally).
  - cpu_latch rises together with cpu_strobe and stays high 4 clks (through c2 of the following slot).
  - A new strobe during a latch window restarts the 4-clk window.
- vid_strobe = mem_rdvalid in a VID slot, combinational, same clk.
- mem_rdvalid in IDLE, CPU_WR or REF slots is ignored.
- cpu_req changing outside c3 has no effect; a write never produces cpu_strobe.
- Reset, including mid-slot: owner = IDLE, vid_run = 0, refresh counter = 0, cpu_rddata = 0. All strobes, mem_req and cpu_latch are 0 on the clk after rst. No command is issued until the first c3 after reset is released.

Optional Feature:
- DRAM_REFRESH_EN defined:
  - A slot counter counts c3 events.
  - refresh_due is set when the counter reaches REF_PERIOD-1, and cleared when REF is granted (the counter resets at the same time).
  - In a REF slot, mem_req = 1, mem_rnw = 1, and mem_addr = {21{1'b1}} marks the refresh command.
  - refresh_due overrides starvation.
- Undefined: refresh_due is tied 0, there is no counter, and the REF state is unreachable.

Decomposition:
- Shared package holds:
  - owner state enumeration (IDLE=0, CPU_RD=1, CPU_WR=2, VID=3, REF=4), 3 bits;
  - DRAM word-address width constant 21;
  - refresh command address constant.
- One sub-module is natural: dram_slot_ctr, the refresh/slot counter with the REF_PERIOD compare, instantiated only under DRAM_REFRESH_EN.

Test Plan:
- Idle bus, CPU read:
  - Stimulus: cpu_req=1, rnw=1, addr=0x12345 at c3; memory returns 0xBEEF with mem_rdvalid at c2.
  - Required: mem_req at next c0 with addr 0x12345 and bsel=11; cpu_strobe at c3 with cpu_rddata=0xBEEF; cpu_latch high 4 clks.
- CPU write:
  - Stimulus: wrbsel=1, wrdata=0x5A.
  - Required: mem_bsel=10, mem_wrdata=0x5A5A, mem_rnw=0; no cpu_strobe.
- Contention, VID_RUN_MAX=4:
  - Stimulus: vid_req and cpu_req held high continuously.
  - Required: VID owns 4 slots with cpu_next=0; cpu_next=1 in the 4th; CPU owns the 5th slot; the pattern repeats.
- Stray data:
  - Stimulus: mem_rdvalid pulsed during IDLE and CPU_WR slots.
  - Required: no cpu_strobe, no vid_strobe, cpu_rddata unchanged.
- Reset mid-read:
  - Stimulus: rst asserted at c1 of a CPU_RD slot.
  - Required: no cpu_strobe in that slot; all outputs 0 next clk; first mem_req only after the first post-reset c3 grant.
- DRAM_REFRESH_EN, REF_PERIOD=8:
  - Stimulus: cpu_req held high.
  - Required: every 8th slot is REF with cpu_next=0 at its grant c3, mem_addr=0x1FFFF F; the CPU is served in all other slots.
